// File: rtl/controle_jogo.sv
// controle_jogo: match sequencing controller sitting between vga, keys,
// entities and tela.
//
// Runs the match state machine (ESPERA, JOGANDO, PAUSADO, FIM), issues the
// one-cycle per-frame step strobe for the entities datapath, and keeps lives,
// a 4-digit BCD score, the enemy respawn delay and the ship invulnerability
// window. Every output is registered.
//
// Ports:
//   CLOCK_50           in   system clock
//   reset              in   synchronous, active-low reset
//   frame_start        in   one-cycle pulse at start of vertical blanking
//   pausa              in   pause level (SW[1]), acted on only at frame_start
//   start              in   debounced start pulse
//   acerto_inimigo     in   ally shot hit the enemy (pulse)
//   acerto_nave        in   enemy shot hit the ship (pulse)
//   estado             out  0=ESPERA 1=JOGANDO 2=PAUSADO 3=FIM
//   atualiza           out  one-cycle entities step enable
//   reinicia_entidades out  one-cycle reload of entity start positions
//   inimigo_vivo       out  enemy alive/visible
//   invulneravel       out  ship invulnerability window active
//   perdeu             out  game-over flag
//   vidas              out  remaining lives
//   pontos             out  score, 4 BCD digits, [15:12] most significant
module controle_jogo #(
  parameter int VIDAS_INICIAIS = 3,
  parameter int FRAMES_RESPAWN = 60,
  parameter int FRAMES_INVULN  = 90
) (
  input  logic        CLOCK_50,
  input  logic        reset,
  input  logic        frame_start,
  input  logic        pausa,
  input  logic        start,
  input  logic        acerto_inimigo,
  input  logic        acerto_nave,
  output logic [1:0]  estado,
  output logic        atualiza,
  output logic        reinicia_entidades,
  output logic        inimigo_vivo,
  output logic        invulneravel,
  output logic        perdeu,
  output logic [1:0]  vidas,
  output logic [15:0] pontos
);

  localparam int RW = $clog2(FRAMES_RESPAWN + 1);
  localparam int IW = $clog2(FRAMES_INVULN + 1);

  localparam logic [1:0]    VIDAS_CARGA = 2'(VIDAS_INICIAIS);
  localparam logic [RW-1:0] RESP_CARGA  = RW'(FRAMES_RESPAWN);
  localparam logic [IW-1:0] INV_CARGA   = IW'(FRAMES_INVULN);

  typedef enum logic [1:0] {
    ESPERA  = 2'd0,
    JOGANDO = 2'd1,
    PAUSADO = 2'd2,
    FIM     = 2'd3
  } estado_t;

  estado_t       estado_q, estado_n;
  logic          atualiza_q, atualiza_n;
  logic          reinicia_q, reinicia_n;
  logic          vivo_q, vivo_n;
  logic          invuln_q, invuln_n;
  logic          perdeu_q, perdeu_n;
  logic [1:0]    vidas_q, vidas_n;
  logic [15:0]   pontos_q, pontos_n;
  logic [RW-1:0] resp_q, resp_n;
  logic [IW-1:0] inv_q, inv_n;
  logic          fatal;
  logic          passo;

  // BCD increment with per-digit carry, saturating at 9999.
  function automatic logic [15:0] bcd_inc(input logic [15:0] v);
    logic [15:0] r;
    logic        carry;
    r     = v;
    carry = 1'b1;
    if (v != 16'h9999) begin
      for (int unsigned i = 0; i < 4; i++) begin
        if (carry) begin
          if (r[4*i +: 4] == 4'd9) begin
            r[4*i +: 4] = 4'd0;
          end else begin
            r[4*i +: 4] = r[4*i +: 4] + 4'd1;
            carry       = 1'b0;
          end
        end
      end
    end
    return r;
  endfunction

  always_ff @(posedge CLOCK_50) begin
    if (!reset) begin
      estado_q   <= ESPERA;
      atualiza_q <= 1'b0;
      reinicia_q <= 1'b0;
      vivo_q     <= 1'b0;
      invuln_q   <= 1'b0;
      perdeu_q   <= 1'b0;
      vidas_q    <= VIDAS_CARGA;
      pontos_q   <= '0;
      resp_q     <= '0;
      inv_q      <= '0;
    end else begin
      estado_q   <= estado_n;
      atualiza_q <= atualiza_n;
      reinicia_q <= reinicia_n;
      vivo_q     <= vivo_n;
      invuln_q   <= invuln_n;
      perdeu_q   <= perdeu_n;
      vidas_q    <= vidas_n;
      pontos_q   <= pontos_n;
      resp_q     <= resp_n;
      inv_q      <= inv_n;
    end
  end

  always_comb begin
    estado_n   = estado_q;
    atualiza_n = 1'b0;
    reinicia_n = 1'b0;
    vivo_n     = vivo_q;
    perdeu_n   = perdeu_q;
    vidas_n    = vidas_q;
    pontos_n   = pontos_q;
    resp_n     = resp_q;
    inv_n      = inv_q;
    fatal      = 1'b0;
    passo      = 1'b0;

    case (estado_q)
      ESPERA, FIM: begin
        if (start) begin
          estado_n   = JOGANDO;
          reinicia_n = 1'b1;
          vidas_n    = VIDAS_CARGA;
          pontos_n   = '0;
          vivo_n     = 1'b1;
          perdeu_n   = 1'b0;
          resp_n     = '0;
          inv_n      = '0;
        end
      end

      JOGANDO: begin
        fatal = acerto_nave && (inv_q == '0) && (vidas_q == 2'd1);
        // A fatal hit suppresses the step, so counters only move on frames
        // that really produce an atualiza pulse.
        passo = frame_start && !pausa && !fatal;

        // Decrements first; the hit handling below overwrites with reloads.
        if (passo) begin
          if (resp_q != '0) begin
            resp_n = resp_q - RW'(1);
            if (resp_q == RW'(1)) vivo_n = 1'b1;
          end
          if (inv_q != '0) inv_n = inv_q - IW'(1);
        end

        if (acerto_inimigo && vivo_q) begin
          vivo_n   = 1'b0;
          resp_n   = RESP_CARGA;
          pontos_n = bcd_inc(pontos_q);
        end

        if (acerto_nave && (inv_q == '0)) begin
          if (fatal) begin
            vidas_n  = 2'd0;
            estado_n = FIM;
            perdeu_n = 1'b1;
            vivo_n   = 1'b0;
          end else begin
            vidas_n = vidas_q - 2'd1;
            inv_n   = INV_CARGA;
          end
        end

        if (!fatal && frame_start) begin
          if (pausa) estado_n   = PAUSADO;
          else       atualiza_n = 1'b1;
        end
      end

      PAUSADO: begin
        if (frame_start && !pausa) estado_n = JOGANDO;
      end

      default: ;
    endcase

    invuln_n = (inv_n != '0);
  end

  assign estado             = estado_q;
  assign atualiza           = atualiza_q;
  assign reinicia_entidades = reinicia_q;
  assign inimigo_vivo       = vivo_q;
  assign invulneravel       = invuln_q;
  assign perdeu             = perdeu_q;
  assign vidas              = vidas_q;
  assign pontos             = pontos_q;

endmodule

// File: doc/controle_jogo.md
Name: controle_jogo

Overview:
- Game-sequencing controller between vga, keys, entities and tela.
- Owns the match state machine (wait, play, pause, game over) and issues a one-cycle per-frame update strobe that steps the entities datapath.
- Keeps lives, BCD score, enemy respawn delay and ship invulnerability window.
- Drives inimigo_vivo and perdeu, replacing the constants currently tied into tela.

Parameters:
VIDAS_INICIAIS, 3, lives loaded at match start (1..3)
FRAMES_RESPAWN, 60, update frames the enemy stays dead after being hit
FRAMES_INVULN, 90, update frames the ship ignores hits after losing a life

Ports:
CLOCK_50  input  1  system clock, 50 MHz
reset  input  1  synchronous, active-low reset
frame_start  input  1  one-cycle pulse from vga at start of vertical blanking
pausa  input  1  level, SW[1]
start  input  1  one-cycle pulse from keys (debounced)
acerto_inimigo  input  1  one-cycle pulse: ally shot hit enemy
acerto_nave  input  1  one-cycle pulse: enemy shot hit ship
estado  output  2  0=ESPERA 1=JOGANDO 2=PAUSADO 3=FIM
atualiza  output  1  one-cycle entities step enable
reinicia_entidades  output  1  one-cycle pulse: entities reload start positions
inimigo_vivo  output  1  enemy alive/visible
invulneravel  output  1  ship invulnerability window active (tela blinks ship)
perdeu  output  1  game-over flag to tela
vidas  output  2  remaining lives
pontos  output  16  score, 4 BCD digits, [15:12] most significant

Behaviour:
- Single clock; reset is synchronous and active-low. All outputs are registered and respond 1 cycle after the causing input edge.
- Reset values:
  - estado=ESPERA (0); atualiza=0; reinicia_entidades=0; inimigo_vivo=0; invulneravel=0; perdeu=0.
  - vidas=VIDAS_INICIAIS; pontos=0; respawn and invulnerability counters=0.
  - Reset mid-match aborts immediately to these values.
- ESPERA or FIM, start=1:
  - Next cycle: estado=JOGANDO, reinicia_entidades=1 for exactly 1 cycle.
  - vidas=VIDAS_INICIAIS, pontos=0, inimigo_vivo=1, perdeu=0, counters cleared.
- All other inputs are ignored in ESPERA and FIM. start is ignored in JOGANDO and PAUSADO.
- JOGANDO, frame_start=1:
  - pausa=0: atualiza=1 next cycle, exactly once per frame.
  - pausa=1: estado=PAUSADO, no atualiza.
- PAUSADO:
  - frame_start with pausa=0 -> JOGANDO; no atualiza for that frame, stepping resumes on the following frame_start.
  - pausa changes between frame_start pulses have no effect: pause and resume are frame-aligned.
  - acerto_* are ignored; counters are frozen.
- Counters: respawn and invulnerability counters decrement only in cycles where atualiza is issued (frame_start in JOGANDO with pausa=0). They never go below 0.
- acerto_inimigo in JOGANDO with inimigo_vivo=1:
  - inimigo_vivo=0, respawn counter=FRAMES_RESPAWN.
  - pontos += 1 in BCD with per-digit carry (0009->0010, 0099->0100); saturates at 9999.
  - Ignored when inimigo_vivo=0.
- Respawn: when the respawn counter decrements from 1 to 0, inimigo_vivo=1 in the same registered update.
- acerto_nave in JOGANDO with invulneravel=0 and vidas>1:
  - vidas -= 1, invulnerability counter=FRAMES_INVULN, invulneravel=1.
  - invulneravel returns to 0 when the counter reaches 0.
- acerto_nave in JOGANDO with invulneravel=0 and vidas=1: vidas=0, estado=FIM, perdeu=1 (held until start or reset), inimigo_vivo=0.
- acerto_nave while invulneravel=1 is ignored.
- Simultaneous events in one cycle (frame_start, acerto_inimigo, acerto_nave): all are applied.
  - Score is counted even when the ship hit is fatal.
  - A fatal hit wins over the frame transition: FIM, no atualiza.
  - A counter reload takes priority over the same-cycle decrement.
- Simultaneous frame_start+pausa=1 and a hit in JOGANDO: the hit is applied, then PAUSADO.

Test Plan:
- Reset low 2 cycles, then high -> estado=0, vidas=3, pontos=0x0000, inimigo_vivo=0, atualiza never pulses on 5 frame_start pulses.
- start pulse -> reinicia_entidades high exactly 1 cycle, estado=1, inimigo_vivo=1; 10 frame_start pulses -> exactly 10 single-cycle atualiza pulses.
- 10 acerto_inimigo pulses, each followed by 60 frames -> pontos=0x0010. After a hit, inimigo_vivo=0 for exactly 60 atualiza pulses. A second hit while dead leaves pontos unchanged. Preload 9999 plus hit -> stays 0x9999.
- acerto_nave -> vidas=2, invulneravel=1. A second hit within 90 frames is ignored. After 90 frames invulneravel=0. Two more hits (spaced >90 frames) -> vidas=0, estado=3, perdeu=1, atualiza stops.
- pausa=1 mid-frame -> still JOGANDO until next frame_start, then estado=2. Hits and counters frozen. pausa=0 -> JOGANDO on next frame_start with no atualiza; atualiza on the following one.
- Fatal acerto_nave and acerto_inimigo in the same cycle as frame_start -> pontos incremented, estado=3, no atualiza. start then gives vidas=3, pontos=0, perdeu=0. reset low mid-match -> all outputs to reset values next cycle.
